alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//  Execute-stage ALU driven by the 4-bit alu_control code from ALU control; consumes that code plus two operands.
//  Single-cycle ops complete in 1 cycle. MUL runs on an iterative shift-add multiplier over several cycles.
//  Valid/ready handshakes on both sides let the pipeline stall while MUL is busy or the result is not taken.
//  Result lives in a one-entry output register; decode/hazard logic upstream stays unchanged.
// PARAMETERS
//  WIDTH      32  operand/result width; VHSUM requires an even value
//  STEP_BITS  1   multiplier bits retired per cycle (1, 2 or 4); MUL_ITERS = WIDTH/STEP_BITS
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      synchronous, active-high reset
//  in_valid      in   1      operation + operands presented
//  in_ready      out  1      block can accept this cycle
//  alu_control   in   4      op code: AND=0 OR=1 ADD=2 SLL=3 SRL=4 SUB=6 SLT=7 MUL=8 VHSUM=9
//  alu_op_a      in   WIDTH  operand A
//  alu_op_b      in   WIDTH  operand B
//  out_valid     out  1      alu_out/zero_flag hold a valid result
//  out_ready     in   1      downstream takes the result this cycle
//  alu_out       out  WIDTH  registered result
//  zero_flag     out  1      registered (alu_out == 0)
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, alu_out=0, zero_flag=0, iteration counter=0, multiplier regs=0.
//   A reset in any state, including mid-MUL, aborts the op and emits no result.
//  Accept = in_valid & in_ready. Operands and code are sampled only on accept; input changes afterwards are ignored.
//  FSM states IDLE, MUL_BUSY, DONE.
//   IDLE: in_ready=1.
//    Accept non-MUL -> result registered, go to DONE. out_valid rises the cycle after accept (latency 1).
//    Accept MUL -> load mcand=A, mplier=B, acc=0, cnt=0, go to MUL_BUSY.
//   MUL_BUSY: in_ready=0.
//    Each cycle: acc += (mcand * mplier[STEP_BITS-1:0]); mcand <<= STEP_BITS; mplier >>= STEP_BITS; cnt++.
//    When cnt reaches MUL_ITERS-1, the final step writes alu_out and the FSM goes to DONE.
//    out_valid rises exactly MUL_ITERS+1 cycles after accept.
//   DONE: out_valid=1; alu_out and zero_flag stay stable until taken. in_ready = out_ready.
//    out_ready & !in_valid -> IDLE.
//    out_ready & in_valid -> same-cycle hand-off: the new op is accepted and treated as accepted from IDLE
//     (non-MUL stays in DONE with the new result next cycle; MUL goes to MUL_BUSY).
//    !out_ready -> hold.
//  Arithmetic, all results WIDTH bits, overflow wraps:
//   ADD/SUB: 2's complement, carry/borrow dropped.
//   SLL/SRL: shift amount = B[$clog2(WIDTH)-1:0]; SRL is logical.
//   SLT: signed compare, result 1 or 0.
//   MUL: low WIDTH bits of the product; signed and unsigned inputs give the same low half.
//   VHSUM: per-half add, {A[hi]+B[hi], A[lo]+B[lo]}, each half wraps independently with no carry between halves.
//   Codes 5 and 10-15: result 0, latency 1, zero_flag=1.
//  zero_flag is always registered together with alu_out.
// STRUCTURE
//  Shared package alu_pkg: op-code localparams (AND_OP..VHSUM_OP), FSM state encoding, WIDTH default.
//  ALU control must import the same package so the codes stay in one place.
//  One sub-module mul_iter (WIDTH, STEP_BITS): ports start/busy/done, A, B, product_lo.
//   Holds mcand/mplier/acc/cnt. alu_multicycle owns the FSM, the single-cycle datapath and the output register.
// TESTING
//  1. rst=1 for 2 cycles mid-stream -> out_valid=0, alu_out=0, zero_flag=0, in_ready=1 on the first cycle after release.
//  2. ADD 7 + 0xFFFFFFFD -> out_valid next cycle, alu_out=4, zero_flag=0; then SUB 5-5 -> alu_out=0, zero_flag=1.
//  3. SLT 0xFFFFFFFF,1 -> 1; SRL 0x80000000 by 31 -> 1; SLL 1 by B=0x21 -> 2 (only 5 LSBs used); code 12 -> 0.
//  4. MUL 12345*678 with STEP_BITS=1 -> out_valid exactly 33 cycles after accept, alu_out=8369910.
//     MUL 0xFFFFFFFF*0xFFFFFFFF -> 1; in_ready=0 throughout MUL_BUSY; repeat with STEP_BITS=4 -> latency 9.
//  5. VHSUM A=0xFFFF0001, B=0x00010002 -> 0x00000003 (upper half wraps to 0).
//  6. Result ready, out_ready=0 for 5 cycles -> alu_out stable, in_ready=0. Then out_ready=1 & in_valid (ADD 1+1)
//     same cycle -> old result consumed, 2 valid next cycle. Separately: rst mid-MUL (cycle 10) -> no out_valid, IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, FSM state encoding and the default datapath width.
// The ALU control decoder imports this package so the codes are defined in one place.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] AND_OP   = 4'd0;
    localparam logic [3:0] OR_OP    = 4'd1;
    localparam logic [3:0] ADD_OP   = 4'd2;
    localparam logic [3:0] SLL_OP   = 4'd3;
    localparam logic [3:0] SRL_OP   = 4'd4;
    localparam logic [3:0] SUB_OP   = 4'd6;
    localparam logic [3:0] SLT_OP   = 4'd7;
    localparam logic [3:0] MUL_OP   = 4'd8;
    localparam logic [3:0] VHSUM_OP = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DONE     = 2'd2
    } alu_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier retiring STEP_BITS multiplier bits per cycle.
// Produces the low WIDTH bits of A*B; done pulses alongside the final accumulated product.
module mul_iter #(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lo
);

    localparam int ITERS = WIDTH / STEP_BITS;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
    logic [WIDTH-1:0] partial, acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    // Partial product of the multiplicand and the low STEP_BITS multiplier bits.
    always_comb begin
        partial = '0;
        for (int j = 0; j < STEP_BITS; j++) begin
            if (mplier_q[j]) begin
                partial = partial + (mcand_q << j);
            end
        end
        acc_d = acc_q + partial;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            mcand_q  <= mcand_q << STEP_BITS;
            mplier_q <= mplier_q >> STEP_BITS;
            acc_q    <= acc_d;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy       = busy_q;
    assign done       = busy_q && (cnt_q == LAST);
    assign product_lo = acc_d;

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with valid/ready handshakes: single-cycle ops register in one cycle,
// MUL is delegated to the iterative multiplier; one-entry output register holds the result.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH     = ALU_WIDTH,
    parameter int STEP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_op_a,
    input  logic [WIDTH-1:0] alu_op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero_flag
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int HALF    = WIDTH / 2;

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] alu_out_q;
    logic             zero_q;
    logic             accept, is_mul, mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0] mul_product, comb_result;

    function automatic logic [WIDTH-1:0] vhsum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [HALF-1:0] hi, lo;
        hi = a[WIDTH-1:HALF] + b[WIDTH-1:HALF];
        lo = a[HALF-1:0] + b[HALF-1:0];
        return {hi, lo};
    endfunction

    function automatic logic [WIDTH-1:0] alu_result(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] a_s, b_s;
        a_s = a;
        b_s = b;
        case (op)
            AND_OP:   return a & b;
            OR_OP:    return a | b;
            ADD_OP:   return a + b;
            SUB_OP:   return a - b;
            SLL_OP:   return a << b[SHAMT_W-1:0];
            SRL_OP:   return a >> b[SHAMT_W-1:0];
            SLT_OP:   return {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            VHSUM_OP: return vhsum(a, b);
            default:  return '0;
        endcase
    endfunction

    mul_iter #(
        .WIDTH     (WIDTH),
        .STEP_BITS (STEP_BITS)
    ) u_mul (
        .clk        (clk),
        .rst        (rst),
        .start      (mul_start),
        .a          (alu_op_a),
        .b          (alu_op_b),
        .busy       (mul_busy),
        .done       (mul_done),
        .product_lo (mul_product)
    );

    assign is_mul      = (alu_control == MUL_OP);
    assign comb_result = alu_result(alu_control, alu_op_a, alu_op_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A DONE-state accept behaves exactly like an IDLE accept (same-cycle hand-off).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = is_mul ? ST_MUL_BUSY : ST_DONE;
            end
            ST_MUL_BUSY: begin
                if (mul_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) state_d = is_mul ? ST_MUL_BUSY : ST_DONE;
                    else          state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = !mul_busy;
            ST_DONE: begin
                in_ready  = out_ready && !mul_busy;
                out_valid = 1'b1;
            end
            default: ;
        endcase
        accept    = in_valid && in_ready;
        mul_start = accept && is_mul;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q <= '0;
            zero_q    <= 1'b0;
        end else if (accept && !is_mul) begin
            alu_out_q <= comb_result;
            zero_q    <= (comb_result == '0);
        end else if (mul_done) begin
            alu_out_q <= mul_product;
            zero_q    <= (mul_product == '0);
        end
    end

    assign alu_out   = alu_out_q;
    assign zero_flag = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle, with STEP_BITS=1 and STEP_BITS=4 instances.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_ready;
    logic [3:0]  ctrl;
    logic [31:0] op_a, op_b;
    logic        v1, v4;
    logic        rdy1, ov1, z1, rdy4, ov4, z4;
    logic [31:0] out1, out4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32), .STEP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .alu_control(ctrl),
        .alu_op_a(op_a), .alu_op_b(op_b), .out_valid(ov1), .out_ready(out_ready),
        .alu_out(out1), .zero_flag(z1));

    alu_multicycle #(.WIDTH(32), .STEP_BITS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .alu_control(ctrl),
        .alu_op_a(op_a), .alu_op_b(op_b), .out_valid(ov4), .out_ready(out_ready),
        .alu_out(out4), .zero_flag(z4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op to dut1 for one cycle; on return we are in the cycle after accept.
    task automatic issue1(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        ctrl = c; op_a = a; op_b = b; v1 = 1'b1;
        step();
        v1 = 1'b0;
    endtask

    task automatic single1(input string tag, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input logic expz);
        issue1(c, a, b);
        chk({tag, "_vld"}, {31'd0, ov1}, 32'd1);
        chk(tag, out1, exp);
        chk({tag, "_z"}, {31'd0, z1}, {31'd0, expz});
        step();
    endtask

    task automatic mul_lat(input string tag, input bit use4, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat, input logic [31:0] exp);
        int lat;
        bit rdy_seen;
        ctrl = 4'd8; op_a = a; op_b = b;
        if (use4) v4 = 1'b1; else v1 = 1'b1;
        step();
        v1 = 1'b0; v4 = 1'b0;
        lat = 1;
        rdy_seen = 1'b0;
        while (!(use4 ? ov4 : ov1) && lat < 200) begin
            if (use4 ? rdy4 : rdy1) rdy_seen = 1'b1;
            step();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_rdy_busy"}, {31'd0, rdy_seen}, 32'd0);
        chk(tag, use4 ? out4 : out1, exp);
        step();
    endtask

    initial begin
        bit held_ok;
        bit seen_v;
        rst = 1'b1; out_ready = 1'b1; v1 = 1'b0; v4 = 1'b0;
        ctrl = 4'd0; op_a = '0; op_b = '0;
        step(); step();
        rst = 1'b0;
        step();

        // Reset mid-stream with a result pending
        out_ready = 1'b0;
        issue1(4'd2, 32'd9, 32'd9);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_vld", {31'd0, ov1}, 32'd0);
        chk("rst_out", out1, 32'd0);
        chk("rst_z", {31'd0, z1}, 32'd0);
        chk("rst_rdy", {31'd0, rdy1}, 32'd1);
        out_ready = 1'b1;
        step();

        single1("add",   4'd2,  32'd7,        32'hFFFFFFFD, 32'd4, 1'b0);
        single1("sub",   4'd6,  32'd5,        32'd5,        32'd0, 1'b1);
        single1("slt",   4'd7,  32'hFFFFFFFF, 32'd1,        32'd1, 1'b0);
        single1("slt_n", 4'd7,  32'd1,        32'hFFFFFFFF, 32'd0, 1'b1);
        single1("srl",   4'd4,  32'h80000000, 32'd31,       32'd1, 1'b0);
        single1("sll",   4'd3,  32'd1,        32'h21,       32'd2, 1'b0);
        single1("and",   4'd0,  32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b0);
        single1("or",    4'd1,  32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0);
        single1("op12",  4'd12, 32'h1234,     32'h5678,     32'd0, 1'b1);
        single1("op5",   4'd5,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b1);
        single1("vhsum", 4'd9,  32'hFFFF0001, 32'h00010002, 32'h00000003, 1'b0);

        mul_lat("mul1",    1'b0, 32'd12345,    32'd678,      33, 32'd8369910);
        mul_lat("mul1_ff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'd1);
        mul_lat("mul4",    1'b1, 32'd12345,    32'd678,      9,  32'd8369910);
        mul_lat("mul4_ff", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 9,  32'd1);
        mul_lat("mul4_sg", 1'b1, 32'hFFFFFFFE, 32'd3,        9,  32'hFFFFFFFA);

        // Back-pressure hold, then same-cycle hand-off
        out_ready = 1'b0;
        issue1(4'd2, 32'd2, 32'd3);
        held_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!ov1 || out1 != 32'd5 || rdy1) held_ok = 1'b0;
            step();
        end
        chk("hold_stable", {31'd0, held_ok}, 32'd1);
        chk("hold_out", out1, 32'd5);
        out_ready = 1'b1;
        ctrl = 4'd2; op_a = 32'd1; op_b = 32'd1; v1 = 1'b1;
        #1;
        chk("handoff_rdy", {31'd0, rdy1}, 32'd1);
        step();
        v1 = 1'b0;
        chk("handoff_vld", {31'd0, ov1}, 32'd1);
        chk("handoff_out", out1, 32'd2);
        step();
        chk("handoff_idle", {31'd0, ov1}, 32'd0);

        // Reset aborts a multiply in flight
        issue1(4'd8, 32'd12345, 32'd678);
        for (int i = 1; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen_v = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ov1) seen_v = 1'b1;
            step();
        end
        chk("abort_vld", {31'd0, seen_v}, 32'd0);
        chk("abort_idle", {31'd0, rdy1}, 32'd1);
        chk("abort_out", out1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
